// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM generator / capture pair.
package pwm_pkg;

    // Default counter width, matching the generator's 32-bit period/width registers.
    localparam int PWM_CNT_W = 32;

    // Capture state machine states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } pwm_cap_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level and produces registered rise/fall strobes.
// rise/fall are registered so every edge sees the same fixed 3-cycle delay from
// pwm_in to the consumer; level is the history flop, aligned with rise/fall.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;

    // Two-flop synchronizer, history flop and edge strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            level <= s2;
            rise  <= s2 & ~level;
            fall  <= ~s2 & level;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-width capture with stuck-line detection.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int               CNT_W   = PWM_CNT_W,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(1_000_000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] width,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pwm_cap_state_t   state;
    logic             lvl;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt_per;
    logic [CNT_W-1:0] cnt_hi;
    logic [CNT_W-1:0] per_inc;
    logic [CNT_W-1:0] hi_inc;
    logic             timeout;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (pwm_in),
        .level (lvl),
        .rise  (rise),
        .fall  (fall)
    );

    // Saturating increments: counters stick at all-ones instead of wrapping.
    // cnt_per counts cycles elapsed since the last rise (or ARM entry), so it
    // is loaded with 1 on restart and equals the period when the next rise lands.
    assign per_inc = (cnt_per == CNT_MAX) ? cnt_per : cnt_per + CNT_ONE;
    assign hi_inc  = (cnt_hi  == CNT_MAX) ? cnt_hi  : cnt_hi  + CNT_ONE;
    assign timeout = (cnt_per >= TIMEOUT);

    // Capture FSM with counters and registered outputs; en low overrides edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt_per     <= '0;
            cnt_hi      <= '0;
            period      <= '0;
            width       <= '0;
            valid       <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                state   <= IDLE;
                cnt_per <= '0;
                cnt_hi  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= ARM;
                        cnt_per <= CNT_ONE;
                        cnt_hi  <= '0;
                    end
                    default: begin
                        if (rise) begin
                            // The first rise after ARM only opens a measurement.
                            if (state != ARM) begin
                                valid  <= 1'b1;
                                period <= cnt_per;
                                width  <= cnt_hi;
                            end
                            state   <= HIGH;
                            cnt_per <= CNT_ONE;
                            cnt_hi  <= CNT_ONE;
                            stuck   <= 1'b0;
                        end else if (timeout) begin
                            state       <= ARM;
                            cnt_per     <= CNT_ONE;
                            cnt_hi      <= '0;
                            stuck       <= 1'b1;
                            stuck_level <= lvl;
                        end else begin
                            cnt_per <= per_inc;
                            if (state == HIGH) begin
                                if (fall) state  <= LOW;
                                else      cnt_hi <= hi_inc;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
